// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction-memory and decode handshakes of the fetch sequencer
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter owner, imem fetch sequencer and redirect handling
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    input  logic                   jmp,
    input  logic [31:0]            jmp_target,
    input  logic                   exc,
    pc_fetch_ctrl_if.master        bus,
    output logic [31:0]            pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_d;
    logic [31:0] pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        pend_valid, pend_valid_d;
    logic [31:0] pend_target, pend_target_d;
    logic        redirect;
    logic [31:0] redirect_raw;
    logic [31:0] redirect_target;

    always_comb begin
        redirect     = exc | jmp | br_taken;
        redirect_raw = br_target;
        if (exc) begin
            redirect_raw = EXC_VEC;
        end else if (jmp) begin
            redirect_raw = jmp_target;
        end
        redirect_target = {redirect_raw[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= 32'h0;
            instr_pc_q  <= 32'h0;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            req_q       <= req_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        req_d         = req_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        case (state)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                if (redirect) begin
                    pc_d = redirect_target;
                end
            end
            FETCH: begin
                req_d = 1'b1;
                if (bus.imem_ack) begin
                    // Data returned for a superseded address is dropped; refetch at the new target.
                    if (redirect) begin
                        pc_d         = redirect_target;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid) begin
                        pc_d         = pend_target;
                        pend_valid_d = 1'b0;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = pc;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = redirect_target;
                end
            end
            HOLD: begin
                // A redirect beats a simultaneous decode handshake: the held word is flushed.
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (bus.instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc + 32'd4;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl with random memory latency and redirects
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic [31:0] pc;

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .exc        (exc),
        .bus        (bus),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    int          nchecks = 0;
    int          nerr    = 0;
    int          ndeliv  = 0;
    int          lat_lo  = 2;
    int          lat_hi  = 2;
    logic [31:0] exp_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] last_pc;
    logic [31:0] mon_e;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a < 32'd12) return (a / 32'd4 + 32'd1) * 32'h11;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: next delivered address is the latest redirect target, else previous plus 4.
    task automatic apply_redirect(input logic e, input logic j, input logic [31:0] jt,
                                  input logic b, input logic [31:0] bt);
        logic [31:0] t;
        exc        = e;
        jmp        = j;
        jmp_target = jt;
        br_taken   = b;
        br_target  = bt;
        if (e || j || b) begin
            t = e ? EXC_VEC : (j ? jt : bt);
            t[1:0] = 2'b00;
            exp_q.delete();
            exp_q.push_back(t);
        end
    endtask

    task automatic wait_deliv(input int n, input string name);
        int k = 0;
        while (ndeliv < n && k < 300) begin
            @(negedge clk); #1;
            k++;
        end
        check(name, 32'(ndeliv >= n), 32'd1);
    endtask

    // sel 0: instr_valid, 1: request waiting for ack, 2: imem_ack
    task automatic wait_for(input int sel, input string name);
        int   k = 0;
        logic hit = 1'b0;
        while (!hit && k < 300) begin
            @(negedge clk); #1;
            case (sel)
                0:       hit = bus.instr_valid;
                1:       hit = bus.imem_req && !bus.imem_ack;
                default: hit = bus.imem_ack;
            endcase
            k++;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // Memory: acks after a per-request latency, drops ack the cycle after.
    int mem_cnt = 0;
    int mem_lat = 0;
    bit mem_started = 0;
    always begin
        @(posedge clk); #1;
        if (!rst || bus.imem_ack) begin
            bus.imem_ack = 1'b0;
            mem_cnt      = 0;
            mem_started  = 0;
        end else if (bus.imem_req) begin
            if (!mem_started) begin
                mem_lat     = $urandom_range(lat_hi, lat_lo);
                mem_started = 1;
            end
            if (mem_cnt >= mem_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_fn(bus.imem_addr);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt     = 0;
            mem_started = 0;
        end
    end

    always @(negedge clk) begin
        if (rst && bus.instr_valid && bus.instr_ready && !(exc || jmp || br_taken)) begin
            if (exp_q.size() == 0) begin
                nchecks++;
                nerr++;
                $display("FAIL sb_empty: got delivery at %h expected none", bus.instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", bus.instr_pc, mon_e);
                check("sb_instr", bus.instr, mem_fn(mon_e));
                exp_q.push_back(mon_e + 32'd4);
            end
            got_pc.push_back(bus.instr_pc);
            got_instr.push_back(bus.instr);
            last_pc = bus.instr_pc;
            ndeliv++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] i0, p0, c0;
        int          d0, n0;
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.instr_ready = 1'b1;
        apply_redirect(0, 0, 32'h0, 0, 32'h0);
        exp_q.push_back(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RESET_PC);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);

        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, RESET_PC);

        // Straight-line fetch, ack two cycles after request.
        wait_deliv(3, "line_timeout");
        check("line_pc0", got_pc[0], 32'h0);
        check("line_pc1", got_pc[1], 32'h4);
        check("line_pc2", got_pc[2], 32'h8);
        check("line_in0", got_instr[0], 32'h11);
        check("line_in1", got_instr[1], 32'h22);
        check("line_in2", got_instr[2], 32'h33);

        // Backpressure in HOLD.
        @(posedge clk); #1; bus.instr_ready = 1'b0;
        wait_for(0, "bp_valid_timeout");
        i0 = bus.instr; p0 = bus.instr_pc; c0 = pc;
        for (int k = 0; k < 5; k++) begin
            check("bp_instr", bus.instr, i0);
            check("bp_instr_pc", bus.instr_pc, p0);
            check("bp_req", 32'(bus.imem_req), 32'd0);
            check("bp_pc", pc, c0);
            @(negedge clk); #1;
        end
        @(posedge clk); #1; bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_adv_valid", 32'(bus.instr_valid), 32'd0);
        check("bp_adv_req", 32'(bus.imem_req), 32'd1);
        check("bp_adv_pc", pc, c0 + 32'd4);

        // Jump while waiting for ack: that data is dropped.
        @(posedge clk); #1; apply_redirect(0, 1, 32'h100, 0, 32'h0);
        @(posedge clk); #1; apply_redirect(0, 0, 32'h0, 0, 32'h0);
        wait_for(2, "jf_ack_timeout");
        @(posedge clk); #1;
        check("jf_addr", bus.imem_addr, 32'h100);
        check("jf_req", 32'(bus.imem_req), 32'd1);
        check("jf_valid", 32'(bus.instr_valid), 32'd0);
        d0 = ndeliv;
        wait_deliv(d0 + 1, "jf_deliv_timeout");
        check("jf_deliv_pc", last_pc, 32'h100);

        // Exception, jump and branch together in HOLD with ready high.
        @(posedge clk); #1; bus.instr_ready = 1'b0;
        wait_for(0, "sim_valid_timeout");
        @(posedge clk); #1;
        d0 = ndeliv;
        apply_redirect(1, 1, 32'h200, 1, 32'h300);
        bus.instr_ready = 1'b1;
        @(posedge clk); #1;
        apply_redirect(0, 0, 32'h0, 0, 32'h0);
        check("sim_valid", 32'(bus.instr_valid), 32'd0);
        check("sim_addr", bus.imem_addr, EXC_VEC);
        check("sim_req", 32'(bus.imem_req), 32'd1);
        check("sim_not_consumed", 32'(ndeliv), 32'(d0));
        wait_deliv(d0 + 1, "sim_deliv_timeout");
        check("sim_deliv_pc", last_pc, EXC_VEC);

        // Unaligned branch near the top of memory, then wrap.
        @(posedge clk); #1;
        n0 = ndeliv;
        apply_redirect(0, 0, 32'h0, 1, 32'hFFFF_FFFE);
        @(posedge clk); #1; apply_redirect(0, 0, 32'h0, 0, 32'h0);
        wait_deliv(n0 + 2, "wrap_timeout");
        check("wrap_pc0", got_pc[n0], 32'hFFFF_FFFC);
        check("wrap_pc1", got_pc[n0 + 1], 32'h0000_0000);

        // Zero-wait memory, ready high: one instruction every two cycles.
        lat_lo = 0; lat_hi = 0;
        wait_deliv(ndeliv + 2, "tput_sync_timeout");
        n0 = ndeliv;
        repeat (20) @(negedge clk);
        #1;
        check("tput_count", 32'(ndeliv - n0), 32'd10);

        // Asynchronous reset between edges while a request is outstanding.
        lat_lo = 2; lat_hi = 2;
        wait_for(1, "ar_req_timeout");
        #2;
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        #1;
        check("ar_req", 32'(bus.imem_req), 32'd0);
        check("ar_valid", 32'(bus.instr_valid), 32'd0);
        check("ar_pc", pc, RESET_PC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ar_restart_req", 32'(bus.imem_req), 32'd1);
        check("ar_restart_addr", bus.imem_addr, RESET_PC);
        d0 = ndeliv;
        wait_deliv(d0 + 1, "ar_deliv_timeout");
        check("ar_deliv_pc", last_pc, RESET_PC);

        // Random latency, backpressure and redirects.
        lat_lo = 0; lat_hi = 3;
        n0 = ndeliv;
        for (int c = 0; c < 600; c++) begin
            logic        e, j, b;
            logic [31:0] jt, bt;
            @(posedge clk); #1;
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 8) begin
                e  = ($urandom_range(0, 3) == 0);
                j  = 1'($urandom_range(0, 1));
                b  = 1'($urandom_range(0, 1));
                if (!e && !j) b = 1'b1;
                jt = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
                bt = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4095));
                apply_redirect(e, j, jt, b, bt);
            end else begin
                apply_redirect(0, 0, 32'h0, 0, 32'h0);
            end
        end
        @(posedge clk); #1;
        apply_redirect(0, 0, 32'h0, 0, 32'h0);
        bus.instr_ready = 1'b1;
        wait_deliv(ndeliv + 3, "drain_timeout");
        check("rand_progress", 32'(ndeliv - n0 > 40), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
